// File: rtl/snake_game_controller.sv
// Snake game sequencer: IDLE/RUN/PAUSE/DEAD state machine, frame-based move scheduler,
// direction latch with reversal rejection and wall collision detection.
module snake_game_controller #(
    parameter int unsigned GRID_W          = 18,
    parameter int unsigned GRID_H          = 18,
    parameter int unsigned COORD_W         = 5,
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned START_X         = 10,
    parameter int unsigned START_Y         = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               start,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [1:0]         dir,
    output logic [1:0]         state,
    output logic               step,
    output logic               game_over,
    output logic [7:0]         step_count
);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPause = 2'd2, StDead = 2'd3} state_e;

    localparam logic [1:0] DirUp    = 2'd0;
    localparam logic [1:0] DirDown  = 2'd1;
    localparam logic [1:0] DirLeft  = 2'd2;
    localparam logic [1:0] DirRight = 2'd3;

    localparam logic [COORD_W-1:0] StartX    = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] StartY    = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] MaxX      = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] MaxY      = COORD_W'(GRID_H - 1);
    localparam logic [5:0]         LastFrame = 6'(FRAMES_PER_STEP - 1);

    state_e             state_q;
    logic [1:0]         pend_dir;
    logic [5:0]         frame_cnt;
    logic               start_q;

    logic               start_rise;
    logic               req_valid;
    logic [1:0]         req_dir;
    logic               move_due;
    logic               wall_hit;
    logic               do_move;
    logic [1:0]         commit_dir;
    logic               req_ok;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;

    assign state      = state_q;
    assign start_rise = start & ~start_q;
    assign move_due   = frame_tick && (frame_cnt == LastFrame);
    assign req_valid  = up | down | left | right;

    always_comb begin
        req_dir = DirRight;
        if (up) begin
            req_dir = DirUp;
        end else if (down) begin
            req_dir = DirDown;
        end else if (left) begin
            req_dir = DirLeft;
        end
    end

    // Next head is only consumed when no wall is hit, so it never wraps.
    always_comb begin
        wall_hit = 1'b0;
        next_x   = head_x;
        next_y   = head_y;
        unique case (pend_dir)
            DirUp: begin
                wall_hit = (head_y == '0);
                next_y   = head_y - COORD_W'(1);
            end
            DirDown: begin
                wall_hit = (head_y == MaxY);
                next_y   = head_y + COORD_W'(1);
            end
            DirLeft: begin
                wall_hit = (head_x == '0);
                next_x   = head_x - COORD_W'(1);
            end
            default: begin
                wall_hit = (head_x == MaxX);
                next_x   = head_x + COORD_W'(1);
            end
        endcase
    end

    // A request is judged against the direction committed at this edge, so a
    // request arriving with a move can never reverse the freshly committed heading.
    assign do_move    = (state_q == StRun) && !start_rise && move_due && !wall_hit;
    assign commit_dir = do_move ? pend_dir : dir;
    assign req_ok     = req_valid && (req_dir != (commit_dir ^ 2'b01));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            head_x     <= StartX;
            head_y     <= StartY;
            dir        <= DirRight;
            pend_dir   <= DirRight;
            frame_cnt  <= '0;
            step       <= 1'b0;
            game_over  <= 1'b0;
            step_count <= '0;
            start_q    <= 1'b0;
        end else begin
            start_q <= start;
            step    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_rise) begin
                        state_q   <= StRun;
                        frame_cnt <= '0;
                    end
                end
                StRun: begin
                    if (req_ok) begin
                        pend_dir <= req_dir;
                    end
                    if (start_rise) begin
                        state_q <= StPause;
                    end else if (move_due) begin
                        frame_cnt <= '0;
                        if (wall_hit) begin
                            state_q   <= StDead;
                            game_over <= 1'b1;
                        end else begin
                            head_x <= next_x;
                            head_y <= next_y;
                            dir    <= pend_dir;
                            step   <= 1'b1;
                            if (step_count != 8'hFF) begin
                                step_count <= step_count + 8'd1;
                            end
                        end
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + 6'd1;
                    end
                end
                StPause: begin
                    if (start_rise) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    if (start_rise) begin
                        state_q    <= StIdle;
                        head_x     <= StartX;
                        head_y     <= StartY;
                        dir        <= DirRight;
                        pend_dir   <= DirRight;
                        step_count <= '0;
                        frame_cnt  <= '0;
                        game_over  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_controller.sv
// Self-checking bench for snake_game_controller: directed scenarios plus random play,
// every output compared each cycle against a rule-level reference model.
module tb_snake_game_controller;

    localparam int GW  = 18;
    localparam int GH  = 18;
    localparam int FPS = 8;
    localparam int SX  = 10;
    localparam int SY  = 10;

    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;
    localparam int IDLE = 0, RUN = 1, PAUSE = 2, DEAD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       start = 1'b0;
    logic [4:0] head_x, head_y;
    logic [1:0] dir, state;
    logic       step, game_over;
    logic [7:0] step_count;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_state, m_x, m_y, m_dir, m_pend, m_cnt, m_steps;
    bit m_go, m_step, m_start_prev;

    snake_game_controller #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(5), .FRAMES_PER_STEP(FPS),
        .START_X(SX), .START_Y(SY)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .up(up), .down(down), .left(left), .right(right), .start(start),
        .head_x(head_x), .head_y(head_y), .dir(dir), .state(state),
        .step(step), .game_over(game_over), .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int opposite(input int d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

    task automatic model_reset();
        m_state = IDLE; m_x = SX; m_y = SY; m_dir = RIGHT; m_pend = RIGHT;
        m_cnt = 0; m_steps = 0; m_go = 0; m_step = 0; m_start_prev = 0;
    endtask

    // One clock edge of game rules, using the inputs currently applied.
    task automatic model_edge();
        bit rise;
        int nx, ny, req;
        rise = start && !m_start_prev;
        m_start_prev = start;
        m_step = 0;
        case (m_state)
            IDLE: if (rise) begin m_state = RUN; m_cnt = 0; end
            RUN: begin
                if (rise) begin
                    m_state = PAUSE;
                end else if (frame_tick) begin
                    if (m_cnt == FPS - 1) begin
                        m_cnt = 0;
                        nx = m_x + ((m_pend == RIGHT) ? 1 : (m_pend == LEFT) ? -1 : 0);
                        ny = m_y + ((m_pend == DOWN) ? 1 : (m_pend == UP) ? -1 : 0);
                        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                            m_state = DEAD;
                            m_go = 1;
                        end else begin
                            m_x = nx; m_y = ny; m_dir = m_pend; m_step = 1;
                            m_steps = (m_steps >= 255) ? 255 : m_steps + 1;
                        end
                    end else begin
                        m_cnt++;
                    end
                end
                if (up || down || left || right) begin
                    req = up ? UP : down ? DOWN : left ? LEFT : RIGHT;
                    if (req != opposite(m_dir)) m_pend = req;
                end
            end
            PAUSE: if (rise) m_state = RUN;
            default: if (rise) begin
                m_state = IDLE; m_x = SX; m_y = SY; m_dir = RIGHT; m_pend = RIGHT;
                m_steps = 0; m_cnt = 0; m_go = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".head_x"}, int'(head_x), m_x);
        check_eq({tag, ".head_y"}, int'(head_y), m_y);
        check_eq({tag, ".dir"}, int'(dir), m_dir);
        check_eq({tag, ".state"}, int'(state), m_state);
        check_eq({tag, ".step"}, int'(step), int'(m_step));
        check_eq({tag, ".game_over"}, int'(game_over), int'(m_go));
        check_eq({tag, ".step_count"}, int'(step_count), m_steps);
    endtask

    // btn = {up, down, left, right}
    task automatic cyc(input bit ft, input bit st, input logic [3:0] btn, input string tag);
        frame_tick = ft; start = st;
        {up, down, left, right} = btn;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic press_start(input logic [3:0] btn);
        cyc(1'b0, 1'b1, btn, "start");
        cyc(1'b0, 1'b0, btn, "start_lo");
    endtask

    task automatic do_tick(input logic [3:0] btn);
        cyc(1'b1, 1'b0, btn, "tick");
        cyc(1'b0, 1'b0, btn, "gap");
    endtask

    task automatic do_move(input logic [3:0] btn);
        for (int i = 0; i < FPS; i++) do_tick(btn);
    endtask

    // Asserted away from the clock edge; outputs must settle before the next edge.
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        frame_tick = 0; start = 0; {up, down, left, right} = 4'b0;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] rb;
        bit         rs;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // T1: start then one full move
        press_start(4'b0);
        check_eq("t1.state_run", int'(state), RUN);
        do_move(4'b0);
        check_eq("t1.head_x", int'(head_x), 11);
        check_eq("t1.head_y", int'(head_y), 10);
        check_eq("t1.count", int'(step_count), 1);

        // T3: run into the right wall
        for (int i = 0; i < 6; i++) do_move(4'b0);
        check_eq("t3.at_edge", int'(head_x), GW - 1);
        do_move(4'b0);
        check_eq("t3.dead", int'(state), DEAD);
        check_eq("t3.game_over", int'(game_over), 1);
        check_eq("t3.head_kept", int'(head_x), GW - 1);
        press_start(4'b0);
        check_eq("t3.idle", int'(state), IDLE);
        check_eq("t3.head_restored", int'(head_x), SX);
        press_start(4'b0);
        check_eq("t3.run_again", int'(state), RUN);

        // T4: pause in the same cycle as a move-due tick
        for (int i = 0; i < FPS - 1; i++) do_tick(4'b0);
        cyc(1'b1, 1'b1, 4'b0, "t4.pause_edge");
        check_eq("t4.paused", int'(state), PAUSE);
        check_eq("t4.no_move", int'(head_x), SX);
        cyc(1'b0, 1'b0, 4'b0, "t4.gap");
        for (int i = 0; i < 20; i++) do_tick(4'b0010);
        press_start(4'b0);
        do_tick(4'b0);
        check_eq("t4.resumed_move", int'(head_x), SX + 1);

        // T2: reversal rejected, perpendicular turn accepted
        do_move(4'b0010);
        check_eq("t2.left_rejected", int'(head_x), SX + 2);
        do_move(4'b1000);
        check_eq("t2.up_y", int'(head_y), SY - 1);
        check_eq("t2.up_dir", int'(dir), UP);

        // T5: start held high from IDLE
        apply_reset();
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 4'b0, "t5.held");
        check_eq("t5.one_transition", int'(state), RUN);
        cyc(1'b0, 1'b0, 4'b0, "t5.release");

        // Random play
        rb = 4'b0;
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) rb = 4'b0;
            rs = rs ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
            cyc(($urandom_range(0, 2) == 0), rs, rb, "rand");
        end

        // T6: step_count saturation on a 2x2 loop
        apply_reset();
        press_start(4'b0);
        for (int i = 0; i < 300; i++) begin
            case (i % 4)
                0:       do_move(4'b0100);
                1:       do_move(4'b0010);
                2:       do_move(4'b1000);
                default: do_move(4'b0001);
            endcase
        end
        check_eq("t6.saturated", int'(step_count), 255);
        check_eq("t6.still_run", int'(state), RUN);
        do_tick(4'b0);
        do_tick(4'b0);
        apply_reset();
        check_eq("t6.reset_count", int'(step_count), 0);
        check_eq("t6.reset_state", int'(state), IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
